sparse_match_scheduler: RTL and testbench



---
 rtl/sparse_sched_pkg.sv | 44 ++++
 rtl/sparse_word_matcher.sv | 44 ++++
 rtl/sparse_match_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_sparse_match_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_sched_pkg.sv
// Shared types and helpers for the sparse match scheduler.
// Default geometry: 32-bit sparsemap words, 8 words per chunk, 10-bit nonzero-data addresses.
// Helper functions work on a fixed WIN_MAX-wide vector. Callers zero-extend narrower words
// and truncate the results, so WIN may be any power of 2 from 4 to WIN_MAX.
package sparse_sched_pkg;

  localparam int WIN_DEF   = 32;
  localparam int DEPTH_DEF = 8;
  localparam int NZ_AW_DEF = 10;

  localparam int SM_AW_DEF = $clog2(DEPTH_DEF);
  localparam int POS_W_DEF = $clog2(WIN_DEF);
  localparam int CNT_W_DEF = $clog2(WIN_DEF) + 1;

  localparam int WIN_MAX   = 64;
  localparam int POS_MAX_W = 6;
  localparam int CNT_MAX_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  function automatic logic [CNT_MAX_W-1:0] popcount(input logic [WIN_MAX-1:0] v);
    logic [CNT_MAX_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIN_MAX; i++) begin
      n = n + CNT_MAX_W'(v[i]);
    end
    return n;
  endfunction

  // Returns 0 when v is all zero; callers qualify the result with |v.
  function automatic logic [POS_MAX_W-1:0] lowest_set(input logic [WIN_MAX-1:0] v);
    logic [POS_MAX_W-1:0] r;
    r = '0;
    for (int i = WIN_MAX - 1; i >= 0; i--) begin
      if (v[i]) r = POS_MAX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sparse_word_matcher.sv
// Combinational match stage for one sparsemap word pair.
// It finds the lowest position that has not been consumed yet and is nonzero in both words,
// and it gives the IFM and filter nonzero counts below that position.
// word_end is asserted when the word has nothing left, or when the last candidate is being accepted.
module sparse_word_matcher
  import sparse_sched_pkg::*;
#(
  parameter int WIN = WIN_DEF
) (
  input  logic [WIN-1:0]         ifm_sm,
  input  logic [WIN-1:0]         fil_sm,
  input  logic [WIN-1:0]         consumed,
  input  logic                   ready,
  output logic                   cand_any,
  output logic [$clog2(WIN)-1:0] pos,
  output logic [$clog2(WIN):0]   ifm_below,
  output logic [$clog2(WIN):0]   fil_below,
  output logic [$clog2(WIN):0]   ifm_cnt,
  output logic [$clog2(WIN):0]   fil_cnt,
  output logic                   word_end
);

  localparam int PW = $clog2(WIN);
  localparam int CW = $clog2(WIN) + 1;

  logic [WIN-1:0] cand;
  logic [WIN-1:0] below_mask;
  logic           single;

  assign cand       = ifm_sm & fil_sm & ~consumed;
  assign cand_any   = |cand;
  assign pos        = PW'(lowest_set(WIN_MAX'(cand)));
  assign below_mask = (WIN'(1) << pos) - WIN'(1);
  // cand & (cand - 1) clears the lowest set bit; a zero result means only p is left.
  assign single     = ~|(cand & (cand - WIN'(1)));

  assign ifm_below  = CW'(popcount(WIN_MAX'(ifm_sm & below_mask)));
  assign fil_below  = CW'(popcount(WIN_MAX'(fil_sm & below_mask)));
  assign ifm_cnt    = CW'(popcount(WIN_MAX'(ifm_sm)));
  assign fil_cnt    = CW'(popcount(WIN_MAX'(fil_sm)));

  assign word_end   = ~cand_any | (ready & single);

endmodule

// File: rtl/sparse_match_scheduler.sv
// Sparse match scheduler. It walks one sub-chunk of IFM and filter sparsemap words and
// presents every position that is nonzero in both, lowest position first, through a
// ready/valid handshake. Each match also carries its IFM and filter nonzero-data addresses.
// Optional macro SPARSE_CLK_GATE_EN: the pointer, base and count registers and the consumed
// mask are clocked by latch-gated clocks. Cycle behaviour is unchanged.
//
// state | meaning
// IDLE  | waiting for start_i; sparsemap inputs ignored
// SCAN  | walking words, presenting matches
// DONE  | one-cycle done_o pulse, then IDLE
module sparse_match_scheduler
  import sparse_sched_pkg::*;
#(
  parameter int WIN   = WIN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NZ_AW = NZ_AW_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [$clog2(DEPTH)-1:0] ifm_first_word_i,
  input  logic [$clog2(DEPTH)-1:0] fil_first_word_i,
  input  logic [$clog2(DEPTH):0]   word_cnt_i,
  input  logic [NZ_AW-1:0]         ifm_nz_base_i,
  input  logic [NZ_AW-1:0]         fil_nz_base_i,
  output logic [$clog2(DEPTH)-1:0] ifm_sm_addr_o,
  output logic [$clog2(DEPTH)-1:0] fil_sm_addr_o,
  input  logic [WIN-1:0]           ifm_sm_i,
  input  logic [WIN-1:0]           fil_sm_i,
  output logic                     match_valid_o,
  input  logic                     match_ready_i,
  output logic [$clog2(WIN)-1:0]   match_pos_o,
  output logic [NZ_AW-1:0]         ifm_nz_addr_o,
  output logic [NZ_AW-1:0]         fil_nz_addr_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(WIN);
  localparam int CW = $clog2(WIN) + 1;

  sched_state_e state_q, state_d;

  logic [AW-1:0]    ifm_ptr_q, ifm_ptr_d;
  logic [AW-1:0]    fil_ptr_q, fil_ptr_d;
  logic [AW:0]      remain_q, remain_d;
  logic [NZ_AW-1:0] ifm_base_q, ifm_base_d;
  logic [NZ_AW-1:0] fil_base_q, fil_base_d;
  logic [WIN-1:0]   consumed_q, consumed_d;
  logic             regs_en;
  logic             cons_en;

  logic             cand_any;
  logic [PW-1:0]    pos;
  logic [CW-1:0]    ifm_below, fil_below, ifm_cnt, fil_cnt;
  logic             word_end;

  logic             in_scan;
  logic             valid;
  logic             hs;
  logic             word_end_scan;

  sparse_word_matcher #(.WIN(WIN)) u_matcher (
    .ifm_sm    (ifm_sm_i),
    .fil_sm    (fil_sm_i),
    .consumed  (consumed_q),
    .ready     (match_ready_i),
    .cand_any  (cand_any),
    .pos       (pos),
    .ifm_below (ifm_below),
    .fil_below (fil_below),
    .ifm_cnt   (ifm_cnt),
    .fil_cnt   (fil_cnt),
    .word_end  (word_end)
  );

  assign in_scan       = (state_q == ST_SCAN);
  assign valid         = in_scan & cand_any;
  assign hs            = valid & match_ready_i;
  assign word_end_scan = in_scan & word_end;

  // Outputs. Match fields are forced to zero while valid is low, so idle and reset read as 0.
  assign ifm_sm_addr_o = ifm_ptr_q;
  assign fil_sm_addr_o = fil_ptr_q;
  assign match_valid_o = valid;
  assign match_pos_o   = valid ? pos : '0;
  assign ifm_nz_addr_o = valid ? (ifm_base_q + NZ_AW'(ifm_below)) : '0;
  assign fil_nz_addr_o = valid ? (fil_base_q + NZ_AW'(fil_below)) : '0;
  assign busy_o        = in_scan;
  assign done_o        = (state_q == ST_DONE);

  // Next state and register updates. start_i overrides any scan in progress.
  always_comb begin
    state_d    = state_q;
    ifm_ptr_d  = ifm_ptr_q;
    fil_ptr_d  = fil_ptr_q;
    remain_d   = remain_q;
    ifm_base_d = ifm_base_q;
    fil_base_d = fil_base_q;
    consumed_d = consumed_q;
    regs_en    = 1'b0;
    cons_en    = 1'b0;
    if (start_i) begin
      ifm_ptr_d  = ifm_first_word_i;
      fil_ptr_d  = fil_first_word_i;
      remain_d   = word_cnt_i;
      ifm_base_d = ifm_nz_base_i;
      fil_base_d = fil_nz_base_i;
      consumed_d = '0;
      regs_en    = 1'b1;
      cons_en    = 1'b1;
      state_d    = (word_cnt_i == '0) ? ST_DONE : ST_SCAN;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (word_end_scan) begin
            regs_en    = 1'b1;
            ifm_ptr_d  = ifm_ptr_q + AW'(1);
            fil_ptr_d  = fil_ptr_q + AW'(1);
            ifm_base_d = ifm_base_q + NZ_AW'(ifm_cnt);
            fil_base_d = fil_base_q + NZ_AW'(fil_cnt);
            remain_d   = remain_q - (AW+1)'(1);
            // An empty word never has consumed bits set, so only a handshake needs to clear the mask.
            cons_en    = hs;
            consumed_d = '0;
            if (remain_q == (AW+1)'(1)) state_d = ST_DONE;
          end else if (hs) begin
            cons_en    = 1'b1;
            consumed_d = consumed_q | (WIN'(1) << pos);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

`ifdef SPARSE_CLK_GATE_EN
  logic gate0_en_l;
  logic gate1_en_l;
  logic gated_clk_0_w;
  logic gated_clk_1_w;

  // Enables are captured while clk_i is low, so the gated clocks cannot glitch in the high phase.
  always_latch begin
    if (!clk_i) begin
      gate0_en_l <= rst_i | regs_en;
      gate1_en_l <= rst_i | cons_en;
    end
  end

  assign gated_clk_0_w = clk_i & gate0_en_l;
  assign gated_clk_1_w = clk_i & gate1_en_l;

  // Pointer, base and count registers on the gated clock.
  always_ff @(posedge gated_clk_0_w) begin
    if (rst_i) begin
      ifm_ptr_q  <= '0;
      fil_ptr_q  <= '0;
      remain_q   <= '0;
      ifm_base_q <= '0;
      fil_base_q <= '0;
    end else begin
      ifm_ptr_q  <= ifm_ptr_d;
      fil_ptr_q  <= fil_ptr_d;
      remain_q   <= remain_d;
      ifm_base_q <= ifm_base_d;
      fil_base_q <= fil_base_d;
    end
  end

  // Consumed mask on its own gated clock.
  always_ff @(posedge gated_clk_1_w) begin
    if (rst_i) consumed_q <= '0;
    else       consumed_q <= consumed_d;
  end
`else
  // Pointer, base and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifm_ptr_q  <= '0;
      fil_ptr_q  <= '0;
      remain_q   <= '0;
      ifm_base_q <= '0;
      fil_base_q <= '0;
    end else if (regs_en) begin
      ifm_ptr_q  <= ifm_ptr_d;
      fil_ptr_q  <= fil_ptr_d;
      remain_q   <= remain_d;
      ifm_base_q <= ifm_base_d;
      fil_base_q <= fil_base_d;
    end
  end

  // Consumed mask.
  always_ff @(posedge clk_i) begin
    if (rst_i)        consumed_q <= '0;
    else if (cons_en) consumed_q <= consumed_d;
  end
`endif

endmodule

// File: tb/tb_sparse_match_scheduler.sv
// Directed bench for sparse_match_scheduler with hand-computed expectations.
// The sparsemap memories are modelled as combinational arrays indexed by the DUT read addresses.
module tb_sparse_match_scheduler;

  localparam int WIN   = 32;
  localparam int DEPTH = 8;
  localparam int NZ_AW = 10;
  localparam int AW    = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [AW-1:0]    ifm_first, fil_first;
  logic [AW:0]      word_cnt;
  logic [NZ_AW-1:0] ifm_base, fil_base;
  logic [AW-1:0]    ifm_sm_addr, fil_sm_addr;
  logic [WIN-1:0]   ifm_sm, fil_sm;
  logic             valid, ready;
  logic [4:0]       pos;
  logic [NZ_AW-1:0] ifm_nz, fil_nz;
  logic             busy, done;

  logic [WIN-1:0]   ifm_mem [DEPTH];
  logic [WIN-1:0]   fil_mem [DEPTH];

  // Stand-alone instance of the match stage, driven with its own vectors.
  logic [WIN-1:0]   r_ifm, r_fil, r_cons;
  logic             r_ready, r_any, r_wend;
  logic [4:0]       r_pos;
  logic [5:0]       r_ib, r_fb, r_ic, r_fc;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  assign ifm_sm = ifm_mem[ifm_sm_addr];
  assign fil_sm = fil_mem[fil_sm_addr];

  sparse_match_scheduler #(.WIN(WIN), .DEPTH(DEPTH), .NZ_AW(NZ_AW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .ifm_first_word_i (ifm_first),
    .fil_first_word_i (fil_first),
    .word_cnt_i       (word_cnt),
    .ifm_nz_base_i    (ifm_base),
    .fil_nz_base_i    (fil_base),
    .ifm_sm_addr_o    (ifm_sm_addr),
    .fil_sm_addr_o    (fil_sm_addr),
    .ifm_sm_i         (ifm_sm),
    .fil_sm_i         (fil_sm),
    .match_valid_o    (valid),
    .match_ready_i    (ready),
    .match_pos_o      (pos),
    .ifm_nz_addr_o    (ifm_nz),
    .fil_nz_addr_o    (fil_nz),
    .busy_o           (busy),
    .done_o           (done)
  );

  sparse_word_matcher #(.WIN(WIN)) u_ref (
    .ifm_sm    (r_ifm),
    .fil_sm    (r_fil),
    .consumed  (r_cons),
    .ready     (r_ready),
    .cand_any  (r_any),
    .pos       (r_pos),
    .ifm_below (r_ib),
    .fil_below (r_fb),
    .ifm_cnt   (r_ic),
    .fil_cnt   (r_fc),
    .word_end  (r_wend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_match(input string tag, input logic [4:0] p, input logic [9:0] ia, input logic [9:0] fa);
    chk({tag, ".valid"}, 32'(valid), 32'd1);
    chk({tag, ".pos"},   32'(pos),   32'(p));
    chk({tag, ".ifm"},   32'(ifm_nz), 32'(ia));
    chk({tag, ".fil"},   32'(fil_nz), 32'(fa));
  endtask

  task automatic do_start(input logic [2:0] fi, input logic [2:0] ff, input logic [3:0] wc,
                          input logic [9:0] ib, input logic [9:0] fb);
    start     = 1'b1;
    ifm_first = fi;
    fil_first = ff;
    word_cnt  = wc;
    ifm_base  = ib;
    fil_base  = fb;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    ifm_first = '0; fil_first = '0; word_cnt = '0; ifm_base = '0; fil_base = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ifm_mem[i] = '0;
      fil_mem[i] = '0;
    end
    r_ifm = 32'h0000_00F0; r_fil = 32'h0000_0030; r_cons = '0; r_ready = 1'b1;

    // match stage on its own
    #1;
    chk("ref1.pos",  32'(r_pos), 32'd4);
    chk("ref1.ib",   32'(r_ib),  32'd0);
    chk("ref1.wend", 32'(r_wend), 32'd0);
    r_cons = 32'h0000_0010; #1;
    chk("ref2.pos",  32'(r_pos), 32'd5);
    chk("ref2.ib",   32'(r_ib),  32'd1);
    chk("ref2.fb",   32'(r_fb),  32'd1);
    chk("ref2.wend", 32'(r_wend), 32'd1);
    r_ifm = 32'hFFFF_FFFF; r_fil = 32'h8000_0000; r_cons = '0; #1;
    chk("ref3.pos",  32'(r_pos), 32'd31);
    chk("ref3.ib",   32'(r_ib),  32'd31);
    chk("ref3.ic",   32'(r_ic),  32'd32);
    r_ifm = 32'h0000_000F; r_fil = 32'h0000_00F0; #1;
    chk("ref4.any",  32'(r_any), 32'd0);
    chk("ref4.wend", 32'(r_wend), 32'd1);

    // reset state
    tick(); tick();
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.busy",  32'(busy),  32'd0);
    chk("rst.done",  32'(done),  32'd0);
    chk("rst.addr",  32'({ifm_sm_addr, fil_sm_addr}), 32'd0);
    chk("rst.nz",    32'({pos, ifm_nz, fil_nz}), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle.busy", 32'(busy), 32'd0);

    // basic match
    ifm_mem[0] = 32'h0000_00F0; fil_mem[0] = 32'h0000_0030;
    do_start(3'd0, 3'd0, 4'd1, 10'd0, 10'd100);
    chk("basic.busy", 32'(busy), 32'd1);
    chk_match("basic.m0", 5'd4, 10'd0, 10'd100);
    tick();
    chk_match("basic.m1", 5'd5, 10'd1, 10'd101);
    tick();
    chk("basic.done",  32'(done),  32'd1);
    chk("basic.valid", 32'(valid), 32'd0);
    tick();
    chk("basic.done_clr", 32'(done), 32'd0);

    // backpressure: ready low for three cycles on the first match
    ready = 1'b0;
    do_start(3'd0, 3'd0, 4'd1, 10'd0, 10'd100);
    chk_match("bp.c1", 5'd4, 10'd0, 10'd100);
    tick();
    chk_match("bp.c2", 5'd4, 10'd0, 10'd100);
    tick();
    chk_match("bp.c3", 5'd4, 10'd0, 10'd100);
    ready = 1'b1;
    #1;
    chk_match("bp.c4", 5'd4, 10'd0, 10'd100);
    tick();
    chk_match("bp.c5", 5'd5, 10'd1, 10'd101);
    tick();
    chk("bp.done", 32'(done), 32'd1);
    tick();

    // multi-word with an empty first word
    ifm_mem[2] = 32'h0000_000F; fil_mem[4] = 32'h0000_00F0;
    ifm_mem[3] = 32'hFFFF_FFFF; fil_mem[5] = 32'h0000_0001;
    ifm_mem[4] = 32'h0000_0006; fil_mem[6] = 32'h0000_0004;
    do_start(3'd2, 3'd4, 4'd3, 10'd10, 10'd20);
    chk("mw.w0.valid", 32'(valid), 32'd0);
    chk("mw.w0.busy",  32'(busy),  32'd1);
    chk("mw.w0.addr",  32'({ifm_sm_addr, fil_sm_addr}), 32'({3'd2, 3'd4}));
    tick();
    chk("mw.w1.addr",  32'({ifm_sm_addr, fil_sm_addr}), 32'({3'd3, 3'd5}));
    chk_match("mw.w1", 5'd0, 10'd14, 10'd24);
    tick();
    chk("mw.w2.addr",  32'({ifm_sm_addr, fil_sm_addr}), 32'({3'd4, 3'd6}));
    chk_match("mw.w2", 5'd2, 10'd47, 10'd25);
    tick();
    chk("mw.done", 32'(done), 32'd1);
    tick();

    // zero-length sub-chunk
    do_start(3'd1, 3'd1, 4'd0, 10'd5, 10'd5);
    chk("zl.done",  32'(done),  32'd1);
    chk("zl.valid", 32'(valid), 32'd0);
    chk("zl.busy",  32'(busy),  32'd0);
    tick();
    chk("zl.idle", 32'(done), 32'd0);

    // pointer wrap from DEPTH-1 to 0
    ifm_mem[7] = 32'h0000_0001; fil_mem[7] = 32'h0000_0001;
    ifm_mem[0] = 32'h0000_0100; fil_mem[0] = 32'h0000_0300;
    do_start(3'd7, 3'd7, 4'd2, 10'd0, 10'd0);
    chk("wrap.a0", 32'({ifm_sm_addr, fil_sm_addr}), 32'({3'd7, 3'd7}));
    chk_match("wrap.m0", 5'd0, 10'd0, 10'd0);
    tick();
    chk("wrap.a1", 32'({ifm_sm_addr, fil_sm_addr}), 32'd0);
    chk_match("wrap.m1", 5'd8, 10'd1, 10'd1);
    tick();
    chk("wrap.done", 32'(done), 32'd1);
    tick();

    // restart mid-scan discards the pending match
    ifm_mem[0] = 32'h0000_00F0; fil_mem[0] = 32'h0000_0030;
    ifm_mem[3] = 32'hFFFF_FFFF; fil_mem[3] = 32'h8000_0000;
    ready = 1'b0;
    do_start(3'd0, 3'd0, 4'd1, 10'd0, 10'd100);
    chk_match("rs.pend", 5'd4, 10'd0, 10'd100);
    do_start(3'd3, 3'd3, 4'd1, 10'd200, 10'd300);
    chk("rs.addr", 32'({ifm_sm_addr, fil_sm_addr}), 32'({3'd3, 3'd3}));
    chk_match("rs.new", 5'd31, 10'd231, 10'd300);

    // reset together with start wins
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rr.valid", 32'(valid), 32'd0);
    chk("rr.busy",  32'(busy),  32'd0);
    chk("rr.done",  32'(done),  32'd0);
    chk("rr.addr",  32'({ifm_sm_addr, fil_sm_addr}), 32'd0);
    chk("rr.nz",    32'({pos, ifm_nz, fil_nz}), 32'd0);
    tick();
    chk("rr.idle",  32'({busy, valid, done}), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
